// File: rtl/ioports_initiator_if.sv
// rtl/ioports_initiator_if.sv - request/response and UART byte-stream signal bundle for ioports_initiator
//
// Signals:
//   req, rw, addr[3:0], wdata[31:0]  request side, driven by the requester
//   busy, done, err, rdata[31:0]     status/result, driven by the initiator
//   txen, txdata[7:0]                byte load strobe to the UART transmitter
//   txready                          UART transmitter can accept a byte
//   rxready, rxdata[7:0]             byte strobe from the UART receiver
// Modports:
//   master  the initiator itself
//   slave   the requester plus UART side (bench or surrounding logic)

interface ioports_initiator_if;
    logic        req;
    logic        rw;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        txen;
    logic [7:0]  txdata;
    logic        txready;
    logic        rxready;
    logic [7:0]  rxdata;

    modport master (
        input  req, rw, addr, wdata, txready, rxready, rxdata,
        output busy, done, err, rdata, txen, txdata
    );

    modport slave (
        output req, rw, addr, wdata, txready, rxready, rxdata,
        input  busy, done, err, rdata, txen, txdata
    );
endinterface

// File: rtl/ioports_initiator.sv
// rtl/ioports_initiator.sv - byte-serial ioports command initiator (parallel request -> UART opcode/data stream)
//
// Ports:
//   clock    system clock (2 MHz)
//   reset_n  asynchronous reset, active low
//   bus      ioports_initiator_if.master:
//            req/rw/addr/wdata in, busy/done/err/rdata out,
//            txen/txdata out with txready in, rxready/rxdata in
//
// Write frame: opcode 0x80|addr, then wdata MSB first; no response.
// Read frame:  opcode addr, then four response bytes MSB first.

module ioports_initiator #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int TOW            = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    ioports_initiator_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        TX_ISSUE,
        TX_GAP,
        RX_WAIT,
        FINISH
    } state_t;

    localparam logic [TOW-1:0] TLAST = TOW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            rw_q;
    logic [3:0]      addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      idx;
    logic [1:0]      rx_cnt;
    logic [TOW-1:0]  tcount;
    // Only the first three response bytes need holding; the fourth goes
    // straight into rdata together with these.
    logic [23:0]     asm_q;

    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [31:0]     rdata_q;
    logic            txen_q;
    logic [7:0]      txdata_q;

    logic [7:0]      cur_byte;

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0:    cur_byte = {rw_q, 3'b000, addr_q};
            3'd1:    cur_byte = wdata_q[31:24];
            3'd2:    cur_byte = wdata_q[23:16];
            3'd3:    cur_byte = wdata_q[15:8];
            3'd4:    cur_byte = wdata_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rw_q     <= 1'b0;
            addr_q   <= 4'h0;
            wdata_q  <= 32'h0;
            idx      <= 3'd0;
            rx_cnt   <= 2'd0;
            tcount   <= '0;
            asm_q    <= 24'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            txen_q   <= 1'b0;
            txdata_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        rw_q    <= bus.rw;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        busy_q  <= 1'b1;
                        state   <= CHECK;
                    end
                end

                CHECK: begin
                    // Only ports 0-7 are readable on the far side.
                    if (!rw_q && addr_q[3]) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= FINISH;
                    end else begin
                        idx   <= 3'd0;
                        state <= TX_ISSUE;
                    end
                end

                TX_ISSUE: begin
                    if (bus.txready) begin
                        txen_q   <= 1'b1;
                        txdata_q <= cur_byte;
                        state    <= TX_GAP;
                    end
                end

                TX_GAP: begin
                    // txready is not looked at here: the UART lowers it one
                    // clock after the load strobe.
                    txen_q <= 1'b0;
                    if (rw_q) begin
                        if (idx == 3'd4) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b0;
                            state  <= FINISH;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= TX_ISSUE;
                        end
                    end else begin
                        tcount <= '0;
                        rx_cnt <= 2'd0;
                        state  <= RX_WAIT;
                    end
                end

                RX_WAIT: begin
                    // A byte arriving on the expiry cycle still counts.
                    if (bus.rxready) begin
                        asm_q  <= {asm_q[15:0], bus.rxdata};
                        tcount <= '0;
                        rx_cnt <= rx_cnt + 2'd1;
                        if (rx_cnt == 2'd3) begin
                            rdata_q <= {asm_q, bus.rxdata};
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state   <= FINISH;
                        end
                    end else if (tcount == TLAST) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= FINISH;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end

                FINISH: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
    assign bus.txen   = txen_q;
    assign bus.txdata = txdata_q;

endmodule

// File: tb/tb_ioports_initiator.sv
// tb/tb_ioports_initiator.sv - scoreboard bench for ioports_initiator with a UART/responder model

module tb_ioports_initiator;

    localparam int TIMEOUT_CYCLES = 20000;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } done_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    ioports_initiator_if bus();

    ioports_initiator #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TOW            (15)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clock) cyc++;

    logic [7:0]  exp_tx[$];
    done_t       exp_done[$];
    logic [31:0] model_rdata = 32'h0;

    int   done_count    = 0;
    int   txen_count    = 0;
    int   last_done_cyc = 0;
    int   req_cyc       = 0;
    int   byte_cyc      = 0;
    int   bp_cycles     = 0;
    logic prev_done     = 1'b0;
    logic prev_txen     = 1'b0;
    done_t mon_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every txen byte and every done against the scoreboard.
    always @(negedge clock) begin
        if (reset_n) begin
            if (prev_done)
                check("busy_low_after_done", 32'(bus.busy), 32'd0);
            if (bus.txen) begin
                txen_count++;
                check("txready_during_txen", 32'(bus.txready), 32'd1);
                check("txen_single_cycle", 32'(prev_txen), 32'd0);
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_txen actual=0x%02h required=no byte", bus.txdata);
                end else begin
                    check("txdata", 32'(bus.txdata), 32'(exp_tx.pop_front()));
                end
            end
            if (bus.done) begin
                done_count++;
                last_done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=err%0d required=no done", bus.err);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("done_err", 32'(bus.err), 32'(mon_d.err));
                    check("done_rdata", bus.rdata, mon_d.rdata);
                end
            end
            prev_done = bus.done;
            prev_txen = bus.txen;
        end else begin
            prev_done = 1'b0;
            prev_txen = 1'b0;
        end
    end

    // UART transmitter model: ready drops the clock after a load and stays
    // low for bp_cycles clocks.
    initial begin
        bus.txready = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.txen && bp_cycles > 0) begin
                @(posedge clock);
                #1 bus.txready = 1'b0;
                repeat (bp_cycles) @(posedge clock);
                #1 bus.txready = 1'b1;
            end
        end
    end

    task automatic start_req(input logic rw, input logic [3:0] addr, input logic [31:0] wdata);
        @(posedge clock);
        #1;
        bus.req   = 1'b1;
        bus.rw    = rw;
        bus.addr  = addr;
        bus.wdata = wdata;
        req_cyc   = cyc;
        @(posedge clock);
        #1;
        bus.req   = 1'b0;
        bus.rw    = 1'($urandom);
        bus.addr  = 4'($urandom);
        bus.wdata = $urandom;
    endtask

    task automatic wait_done(input int start, input int budget, input string name);
        int n = 0;
        while (done_count == start && n < budget) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (done_count == start) begin
            failures++;
            $display("FAIL %s_done_timeout actual=no done required=done within %0d clocks", name, budget);
        end
        check({name, "_bytes_left"}, 32'(exp_tx.size()), 32'd0);
    endtask

    task automatic wait_txen(input int target, input int budget, input string name);
        int n = 0;
        while (txen_count < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (txen_count < target) begin
            failures++;
            $display("FAIL %s_txen_timeout actual=%0d required=%0d", name, txen_count, target);
        end
    endtask

    task automatic expect_write(input logic [3:0] addr, input logic [31:0] wdata);
        exp_tx.push_back({4'h8, addr});
        for (int i = 3; i >= 0; i--)
            exp_tx.push_back(wdata[8*i +: 8]);
        exp_done.push_back('{1'b0, model_rdata});
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] wdata);
        int start = done_count;
        expect_write(addr, wdata);
        start_req(1'b1, addr, wdata);
        wait_done(start, 4000, "write");
    endtask

    // Read with nbytes reply bytes (MSB first from reply), each after gap clocks.
    task automatic do_read(input logic [3:0] addr, input logic [31:0] reply,
                           input int nbytes, input int gap);
        int start = done_count;
        int t0    = txen_count;
        if (addr[3]) begin
            exp_done.push_back('{1'b1, model_rdata});
        end else begin
            exp_tx.push_back({4'h0, addr});
            if (nbytes == 4)
                model_rdata = reply;
            exp_done.push_back('{(nbytes < 4), model_rdata});
        end
        start_req(1'b0, addr, $urandom);
        if (!addr[3]) begin
            wait_txen(t0 + 1, 4000, "read_opcode");
            for (int i = 0; i < nbytes; i++) begin
                repeat (gap) @(posedge clock);
                #1;
                bus.rxready = 1'b1;
                bus.rxdata  = reply[8*(3-i) +: 8];
                byte_cyc    = cyc;
                @(posedge clock);
                #1;
                bus.rxready = 1'b0;
                bus.rxdata  = 8'($urandom);
            end
        end
        wait_done(start, TIMEOUT_CYCLES + 4000, "read");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int d0;
        logic        rw_r;
        logic [3:0]  a_r;
        logic [31:0] v_r;

        bus.req     = 1'b0;
        bus.rw      = 1'b0;
        bus.addr    = 4'h0;
        bus.wdata   = 32'h0;
        bus.rxready = 1'b0;
        bus.rxdata  = 8'h00;

        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_txen", 32'(bus.txen), 32'd0);
        check("reset_txdata", 32'(bus.txdata), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Plain write with continuous txready.
        do_write(4'h6, 32'h12345678);

        // Read of port 3, reply bytes 174 clocks apart.
        do_read(4'h3, 32'hABCD0001, 4, 174);

        // Backpressure: ready held low 50 clocks after every load.
        bp_cycles = 50;
        t0 = txen_count;
        do_write(4'hA, 32'hDEADBEEF);
        check("bp_txen_count", 32'(txen_count - t0), 32'd5);
        bp_cycles = 0;

        // Two reply bytes only: timeout, rdata keeps its value.
        do_read(4'h2, 32'h5566_0000, 2, 10);
        check("timeout_latency", 32'(last_done_cyc - (byte_cyc + 1)), 32'(TIMEOUT_CYCLES));

        // Illegal read address: no byte sent; done in the third clock of the
        // request (req cycle, CHECK cycle, done cycle).
        t0 = txen_count;
        do_read(4'h9, 32'h0, 0, 0);
        check("illegal_latency", 32'(last_done_cyc - req_cyc), 32'd2);
        check("illegal_no_txen", 32'(txen_count - t0), 32'd0);

        // req and stray rxready pulsed mid-write are ignored.
        t0 = txen_count;
        d0 = done_count;
        expect_write(4'hF, 32'h0F1E2D3C);
        start_req(1'b1, 4'hF, 32'h0F1E2D3C);
        repeat (2) @(posedge clock);
        #1;
        bus.req  = 1'b1;
        bus.rw   = 1'b1;
        bus.addr = 4'h1;
        @(posedge clock);
        #1;
        bus.req     = 1'b0;
        bus.rxready = 1'b1;
        bus.rxdata  = 8'h99;
        @(posedge clock);
        #1;
        bus.rxready = 1'b0;
        wait_done(d0, 4000, "ignored_req");
        repeat (20) @(posedge clock);
        check("ignored_txen_count", 32'(txen_count - t0), 32'd5);
        check("ignored_done_count", 32'(done_count - d0), 32'd1);

        // Reset abort after the second byte of a write.
        t0 = txen_count;
        expect_write(4'h5, 32'hCAFEF00D);
        start_req(1'b1, 4'h5, 32'hCAFEF00D);
        wait_txen(t0 + 2, 4000, "abort");
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        check("abort_rdata", bus.rdata, 32'd0);
        check("abort_txen", 32'(bus.txen), 32'd0);
        check("abort_txdata", 32'(bus.txdata), 32'd0);
        exp_tx.delete();
        exp_done.delete();
        model_rdata = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        do_write(4'h5, 32'h01020304);

        // Randomised traffic.
        for (int k = 0; k < 16; k++) begin
            rw_r      = 1'($urandom);
            a_r       = 4'($urandom);
            v_r       = $urandom;
            bp_cycles = $urandom_range(0, 5);
            if (rw_r)
                do_write(a_r, v_r);
            else
                do_read(a_r, v_r, 4, $urandom_range(2, 30));
            bp_cycles = 0;
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        repeat (10) @(posedge clock);
        check("final_tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("final_done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
